// File: rtl/bet_round_ctrl_if.sv
// Bet / result / status bundle between the input logic, the dealing FSM and bet_round_ctrl.
interface bet_round_ctrl_if;
  logic       place_bet;
  logic [1:0] bet_type;
  logic [7:0] bet_amount;
  logic       result_valid;
  logic       dealerwin;
  logic       playerwin;
  logic [7:0] balance;
  logic       bet_open;
  logic       bet_locked;
  logic       bet_reject;
  logic       round_done;
  logic       won;
  logic       broke;

  // Upstream side: issues bets and results, observes round status
  modport master (
    output place_bet, bet_type, bet_amount, result_valid, dealerwin, playerwin,
    input  balance, bet_open, bet_locked, bet_reject, round_done, won, broke
  );

  // Controller side
  modport slave (
    input  place_bet, bet_type, bet_amount, result_valid, dealerwin, playerwin,
    output balance, bet_open, bet_locked, bet_reject, round_done, won, broke
  );
endinterface

// File: rtl/bet_round_ctrl.sv
// Baccarat betting-round sequencer: validates and locks a bet, waits for the
// round outcome, settles the balance register and flags game over at zero.
// Status flags are registered one cycle behind the state register.
module bet_round_ctrl #(
  parameter logic [7:0]  INIT_BALANCE = 8'd50,
  parameter int unsigned TIE_MULT     = 8
) (
  input  logic            slow_clock,
  input  logic            reset,
  bet_round_ctrl_if.slave bus
);

  localparam int unsigned BAL_W  = 8;
  localparam int unsigned CALC_W = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOCKED = 3'd1,
    SETTLE = 3'd2,
    DONE   = 3'd3,
    BROKE  = 3'd4
  } state_t;

  state_t             state, next_state;
  logic [1:0]         type_q, type_d;
  logic [BAL_W-1:0]   amt_q, amt_d;
  logic               dw_q, dw_d, pw_q, pw_d;
  logic [BAL_W-1:0]   settle_q, settle_d;
  logic               settle_won_q, settle_won_d;
  logic [BAL_W-1:0]   bal_q, bal_d;
  logic               won_q, won_d;
  logic               reject_q, reject_d;
  logic               done_q, done_d;
  logic               open_q, locked_q, broke_q;

  logic [CALC_W-1:0]  bal_ext, amt_ext, tie_sum, win_sum;
  logic               bet_ok, tie;

  // Clamp a widened balance back into the 8-bit register range
  function automatic logic [BAL_W-1:0] sat8(input logic [CALC_W-1:0] v);
    return (v > CALC_W'(255)) ? {BAL_W{1'b1}} : v[BAL_W-1:0];
  endfunction

  // Settlement arithmetic and bet validity
  always_comb begin
    bal_ext = CALC_W'(bal_q);
    amt_ext = CALC_W'(amt_q);
    tie_sum = bal_ext + CALC_W'(TIE_MULT) * amt_ext;
    win_sum = bal_ext + amt_ext;
    tie     = dw_q & pw_q;
    bet_ok  = (bus.bet_type != 2'b00) && (bus.bet_amount != 8'd0) &&
              (bus.bet_amount <= bal_q);
  end

  // State register
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and datapath next values
  always_comb begin
    next_state   = state;
    type_d       = type_q;
    amt_d        = amt_q;
    dw_d         = dw_q;
    pw_d         = pw_q;
    settle_d     = settle_q;
    settle_won_d = settle_won_q;
    bal_d        = bal_q;
    won_d        = won_q;
    reject_d     = 1'b0;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.place_bet) begin
          if (bet_ok) begin
            type_d     = bus.bet_type;
            amt_d      = bus.bet_amount;
            next_state = LOCKED;
          end else begin
            reject_d   = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (bus.result_valid) begin
          dw_d       = bus.dealerwin;
          pw_d       = bus.playerwin;
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (tie && (type_q == 2'b11)) begin
          settle_d     = sat8(tie_sum);
          settle_won_d = 1'b1;
        end else if (tie || (!dw_q && !pw_q)) begin
          settle_d     = bal_q;
          settle_won_d = 1'b0;
        end else if ((pw_q && (type_q == 2'b01)) || (dw_q && (type_q == 2'b10))) begin
          settle_d     = sat8(win_sum);
          settle_won_d = 1'b1;
        end else begin
          settle_d     = bal_q - amt_q;
          settle_won_d = 1'b0;
        end
        next_state = DONE;
      end
      DONE: begin
        bal_d      = settle_q;
        won_d      = settle_won_q;
        done_d     = 1'b1;
        next_state = (settle_q == '0) ? BROKE : IDLE;
      end
      BROKE: begin
        next_state = BROKE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      type_q       <= 2'b00;
      amt_q        <= '0;
      dw_q         <= 1'b0;
      pw_q         <= 1'b0;
      settle_q     <= INIT_BALANCE;
      settle_won_q <= 1'b0;
      bal_q        <= INIT_BALANCE;
      won_q        <= 1'b0;
      reject_q     <= 1'b0;
      done_q       <= 1'b0;
      open_q       <= 1'b1;
      locked_q     <= 1'b0;
      broke_q      <= 1'b0;
    end else begin
      type_q       <= type_d;
      amt_q        <= amt_d;
      dw_q         <= dw_d;
      pw_q         <= pw_d;
      settle_q     <= settle_d;
      settle_won_q <= settle_won_d;
      bal_q        <= bal_d;
      won_q        <= won_d;
      reject_q     <= reject_d;
      done_q       <= done_d;
      open_q       <= (state == IDLE);
      locked_q     <= (state == LOCKED);
      broke_q      <= (state == BROKE);
    end
  end

  assign bus.balance    = bal_q;
  assign bus.bet_open   = open_q;
  assign bus.bet_locked = locked_q;
  assign bus.bet_reject = reject_q;
  assign bus.round_done = done_q;
  assign bus.won        = won_q;
  assign bus.broke      = broke_q;

endmodule
